sha_input_manager: RTL and testbench



---
 rtl/sha_pkg.sv | 28 ++
 rtl/sha_nonce_counter.sv | 33 +++
 rtl/sha_input_manager.sv | 151 +++++++++++++++
 tb/tb_sha_input_manager.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA256 mining front end.
// Holds the dispatcher state encoding, the job word widths and a
// constant-friendly ceil(log2) helper used to size counters.
package sha_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MIDSTATE_W = 256;
    localparam int TAIL_W     = 96;
    localparam int NONCE_W    = 32;

    // Smallest n with 2**n >= value; clog2(1) is 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sha_nonce_counter.sv
// Offset counter that walks one nonce slice.
// Clear has priority over enable, and the count saturates at the top of the
// slice so a stray enable can never wrap the offset back into searched space.
module sha_nonce_counter
#(
    parameter int OW = 7
)
(
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [OW-1:0] o_offset,
    output logic          o_last
);

    logic [OW-1:0] r_offset;

    // Offset register: clear on a new job, step once per enabled cycle, hold at the top
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_offset <= '0;
        end else if (i_clear) begin
            r_offset <= '0;
        end else if (i_enable && !o_last) begin
            r_offset <= r_offset + OW'(1);
        end
    end

    assign o_last   = (r_offset == {OW{1'b1}});
    assign o_offset = r_offset;

endmodule

// File: rtl/sha_input_manager.sv
// Work dispatcher for the SHA256 core array.
// Captures one job, broadcasts it to all cores and sweeps the nonce space,
// each core owning the slice selected by the top CW nonce bits. A job ends on
// slice exhaustion (after draining the core pipeline), on found, or on abort.
// Optional feature macro: SHA_INPUT_STALL_EN adds a stall input that pauses
// the sweep and freezes the drain countdown.
module sha_input_manager
    import sha_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int NONCE_BITS = 32,
    parameter int PIPE_DEPTH = 128
)
(
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [MIDSTATE_W-1:0]        job_midstate,
    input  logic [TAIL_W-1:0]            job_tail,
    input  logic                         found,
    input  logic                         abort,
`ifdef SHA_INPUT_STALL_EN
    input  logic                         stall,
`endif
    output logic [MIDSTATE_W-1:0]        core_midstate,
    output logic [TAIL_W-1:0]            core_tail,
    output logic [NONCE_W*NUM_CORES-1:0] core_nonce,
    output logic                         core_enable,
    output logic                         busy,
    output logic                         exhausted
);

    localparam int CW = clog2(NUM_CORES);
    localparam int OW = NONCE_BITS - CW;
    localparam int DW = clog2(PIPE_DEPTH + 1);

    state_t                r_state;
    state_t                w_next;
    logic [DW-1:0]         r_drain;
    logic                  r_busy;
    logic                  r_exhausted;
    logic [MIDSTATE_W-1:0] r_midstate;
    logic [TAIL_W-1:0]     r_tail;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_exhaustNext;
    logic [OW-1:0]         w_offset;
    logic                  w_last;

`ifdef SHA_INPUT_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_accept    = (r_state == IDLE) && job_valid;
    assign core_enable = (r_state == RUN) && !w_stall;
    assign job_ready   = (r_state == IDLE);
    assign busy        = r_busy;
    assign exhausted   = r_exhausted;

    sha_nonce_counter #(.OW(OW)) u_counter (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_clear  (w_accept),
        .i_enable (core_enable),
        .o_offset (w_offset),
        .o_last   (w_last)
    );

    // Next-state decode: abort beats found, and both beat slice exhaustion
    always_comb begin
        w_next        = r_state;
        w_exhaustNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (job_valid) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (abort || found) begin
                    w_next = IDLE;
                end else if (w_last && !w_stall) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || found) begin
                    w_next = IDLE;
                end else if ((r_drain == '0) && !w_stall) begin
                    w_next        = IDLE;
                    w_exhaustNext = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register plus the registered busy flag and one-cycle exhausted pulse
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != IDLE);
            r_exhausted <= w_exhaustNext;
        end
    end

    // Drain countdown covers the cycles the last nonces spend inside the cores
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_drain <= '0;
        end else if ((r_state == RUN) && (w_next == DRAIN)) begin
            r_drain <= DW'(PIPE_DEPTH - 1);
        end else if ((r_state == DRAIN) && !w_stall && (r_drain != '0)) begin
            r_drain <= r_drain - DW'(1);
        end
    end

    // Job words are held from acceptance until the next accepted job
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_midstate <= '0;
            r_tail     <= '0;
        end else if (w_accept) begin
            r_midstate <= job_midstate;
            r_tail     <= job_tail;
        end
    end

    assign core_midstate = r_midstate;
    assign core_tail     = r_tail;

    // Per-core nonce: core index in the top bits, shared offset below; zero while idle
    always_comb begin
        core_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (r_busy) begin
                core_nonce[NONCE_W*i +: NONCE_W] = (NONCE_W'(i) << OW) | NONCE_W'(w_offset);
            end
        end
    end

endmodule

// File: tb/tb_sha_input_manager.sv
// Directed bench for sha_input_manager with 2 cores, 8-bit nonces and a
// 4-deep core pipeline. Inputs are driven and outputs sampled on the falling
// edge. Stall checks are compiled in when SHA_INPUT_STALL_EN is defined.
module tb_sha_input_manager;

    localparam int NUM_CORES  = 2;
    localparam int NONCE_BITS = 8;
    localparam int PIPE_DEPTH = 4;

    logic         clk;
    logic         n_rst;
    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_midstate;
    logic [95:0]  job_tail;
    logic         found;
    logic         abort;
    logic         stall;
    logic [255:0] core_midstate;
    logic [95:0]  core_tail;
    logic [63:0]  core_nonce;
    logic         core_enable;
    logic         busy;
    logic         exhausted;

    int checkCount;
    int errorCount;

    localparam logic [255:0] MID_A  = {32{8'hA5}};
    localparam logic [255:0] MID_B  = {32{8'h3C}};
    localparam logic [255:0] MID_C  = {16{16'hC0DE}};
    localparam logic [255:0] MID_D  = {8{32'hDEADBEEF}};
    localparam logic [95:0]  TAIL_A = {8{12'h123}};
    localparam logic [95:0]  TAIL_B = {3{32'h89ABCDEF}};

    sha_input_manager #(
        .NUM_CORES  (NUM_CORES),
        .NONCE_BITS (NONCE_BITS),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_midstate  (job_midstate),
        .job_tail      (job_tail),
        .found         (found),
        .abort         (abort),
`ifdef SHA_INPUT_STALL_EN
        .stall         (stall),
`endif
        .core_midstate (core_midstate),
        .core_tail     (core_tail),
        .core_nonce    (core_nonce),
        .core_enable   (core_enable),
        .busy          (busy),
        .exhausted     (exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer a job in IDLE and return on the first RUN cycle (offset 0)
    task automatic applyStimulus(input logic [255:0] mid, input logic [95:0] tail);
        job_midstate = mid;
        job_tail     = tail;
        job_valid    = 1'b1;
        checkOutput("jobReadyOffer", job_ready, 1);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // Count enabled cycles while checking both slice nonces against the offset
    task automatic sweepEnabled(inout int enCount);
        int guard;
        guard = 0;
        while (core_enable === 1'b1 && guard < 300) begin
            checkOutput("nonce0", core_nonce[31:0], 256'(enCount));
            checkOutput("nonce1", core_nonce[63:32], 256'(32'h80 + enCount));
            enCount++;
            guard++;
            @(negedge clk);
        end
    endtask

    // Wait through the drain and check the exhausted pulse that ends it
    task automatic checkDrain();
        int lowCount;
        lowCount = 0;
        while (exhausted !== 1'b1 && lowCount < 50) begin
            checkOutput("drainEnable", core_enable, 0);
            lowCount++;
            @(negedge clk);
        end
        checkOutput("drainCycles", 256'(lowCount), 256'(PIPE_DEPTH));
        checkOutput("exhaustedPulse", exhausted, 1);
        checkOutput("readyAfterDrain", job_ready, 1);
        checkOutput("idleAfterDrain", busy, 0);
    endtask

    initial begin
        int enCount;
        checkCount   = 0;
        errorCount   = 0;
        n_rst        = 1'b0;
        job_valid    = 1'b0;
        job_midstate = '0;
        job_tail     = '0;
        found        = 1'b0;
        abort        = 1'b0;
        stall        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstReady", job_ready, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstEnable", core_enable, 0);
        checkOutput("rstNonce", core_nonce, 0);
        checkOutput("rstExhausted", exhausted, 0);
        checkOutput("rstMidstate", core_midstate, 0);
        n_rst = 1'b1;
        @(negedge clk);
        checkOutput("idleReady", job_ready, 1);
        checkOutput("idleNonce", core_nonce, 0);

        // Full sweep of both slices followed by the pipeline drain
        applyStimulus(MID_A, TAIL_A);
        checkOutput("runBusy", busy, 1);
        checkOutput("runReady", job_ready, 0);
        checkOutput("runMidstate", core_midstate, MID_A);
        checkOutput("runTail", core_tail, 256'(TAIL_A));
        enCount = 0;
        sweepEnabled(enCount);
        checkOutput("enabledCycles", 256'(enCount), 128);
        checkDrain();
        checkOutput("holdMidstate", core_midstate, MID_A);
        @(negedge clk);
        checkOutput("exhaustedOneCycle", exhausted, 0);
        checkOutput("idleNonceAgain", core_nonce, 0);

        // found at offset 0x10 stops the job without a drain
        applyStimulus(MID_B, TAIL_B);
        repeat (16) @(negedge clk);
        checkOutput("foundAtOffset", core_nonce[31:0], 32'h10);
        checkOutput("foundEnableBefore", core_enable, 1);
        found = 1'b1;
        @(negedge clk);
        found = 1'b0;
        checkOutput("foundEnableAfter", core_enable, 0);
        checkOutput("foundBusy", busy, 0);
        checkOutput("foundReady", job_ready, 1);
        checkOutput("foundMidstate", core_midstate, MID_B);
        repeat (8) begin
            checkOutput("foundNoExhaust", exhausted, 0);
            @(negedge clk);
        end

        // found in IDLE is ignored
        found = 1'b1;
        @(negedge clk);
        found = 1'b0;
        checkOutput("foundIdleBusy", busy, 0);

        // found and abort together on the last offset: straight to IDLE
        applyStimulus(MID_A, TAIL_A);
        repeat (127) @(negedge clk);
        checkOutput("lastOffset0", core_nonce[31:0], 32'h7F);
        checkOutput("lastOffset1", core_nonce[63:32], 32'hFF);
        found = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        found = 1'b0;
        abort = 1'b0;
        checkOutput("lastAbortBusy", busy, 0);
        checkOutput("lastAbortEnable", core_enable, 0);
        repeat (8) begin
            checkOutput("lastAbortNoDrain", busy, 0);
            checkOutput("lastAbortNoExhaust", exhausted, 0);
            @(negedge clk);
        end

        // Back-to-back jobs with job_valid held high throughout
        job_midstate = MID_C;
        job_tail     = TAIL_B;
        job_valid    = 1'b1;
        @(negedge clk);
        job_midstate = MID_D;
        job_tail     = TAIL_A;
        checkOutput("b2bMidstate1", core_midstate, MID_C);
        checkOutput("b2bReadyLow", job_ready, 0);
        enCount = 0;
        sweepEnabled(enCount);
        checkOutput("b2bEnabledCycles", 256'(enCount), 128);
        checkDrain();
        checkOutput("b2bHoldMidstate", core_midstate, MID_C);
        @(negedge clk);
        job_valid = 1'b0;
        checkOutput("b2bSecondBusy", busy, 1);
        checkOutput("b2bSecondEnable", core_enable, 1);
        checkOutput("b2bRestart0", core_nonce[31:0], 0);
        checkOutput("b2bRestart1", core_nonce[63:32], 32'h80);
        checkOutput("b2bMidstate2", core_midstate, MID_D);
        checkOutput("b2bTail2", core_tail, 256'(TAIL_A));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortRunBusy", busy, 0);

        // abort in IDLE does not block an offered job
        job_midstate = MID_B;
        job_valid    = 1'b1;
        abort        = 1'b1;
        @(negedge clk);
        job_valid = 1'b0;
        abort     = 1'b0;
        checkOutput("abortIdleAccept", busy, 1);
        checkOutput("abortIdleMidstate", core_midstate, MID_B);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abortIdleCleanup", busy, 0);

`ifdef SHA_INPUT_STALL_EN
        // Stall at offset 0x20 holds the nonces without losing enabled cycles
        applyStimulus(MID_A, TAIL_A);
        enCount = 0;
        while (enCount < 32) begin
            enCount++;
            @(negedge clk);
        end
        checkOutput("stallOffset", core_nonce[31:0], 32'h20);
        stall = 1'b1;
        repeat (5) begin
            #1;
            checkOutput("stallEnable", core_enable, 0);
            checkOutput("stallNonce0", core_nonce[31:0], 32'h20);
            checkOutput("stallNonce1", core_nonce[63:32], 32'hA0);
            @(negedge clk);
        end
        stall = 1'b0;
        sweepEnabled(enCount);
        checkOutput("stallEnabledCycles", 256'(enCount), 128);
        checkDrain();
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
